// File: rtl/key_expander.sv
// Iterative AES-128 key schedule: key is accepted in IDLE, then one round key
// per clock is written into its slot of expanded_key until round 10 is done.
module key_expander (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [127:0]    key,
  output logic            busy,
  output logic            done,
  output logic            key_valid,
  output logic [1407:0]   expanded_key
);

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  // FIPS-197 S-box, entry 0x00 in the MSBs.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t        state;
  state_t        state_next;
  logic [3:0]    round_cnt;
  logic [7:0]    rcon;
  logic [127:0]  prev_key;
  logic [127:0]  round_key;
  logic [127:0]  slot [11];

  logic [31:0]   w3_rot;
  logic [31:0]   temp;
  logic [31:0]   w0_n;
  logic [31:0]   w1_n;
  logic [31:0]   w2_n;
  logic [31:0]   w3_n;

  // Byte x lives at bit offset 8*(255-x) = {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One FIPS-197 round of the key schedule from the previous round key.
  always_comb begin
    w3_rot    = {prev_key[23:0], prev_key[31:24]};
    temp      = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                 sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])} ^ {rcon, 24'h000000};
    w0_n      = prev_key[127:96] ^ temp;
    w1_n      = prev_key[95:64]  ^ w0_n;
    w2_n      = prev_key[63:32]  ^ w1_n;
    w3_n      = prev_key[31:0]   ^ w2_n;
    round_key = {w0_n, w1_n, w2_n, w3_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (round_cnt == 4'd10) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == EXPAND);
    expanded_key = '0;
    for (int unsigned r = 0; r < 11; r++) begin
      expanded_key[(10 - r) * 128 +: 128] = slot[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 11; i++) slot[i] <= '0;
      prev_key  <= '0;
      round_cnt <= '0;
      rcon      <= 8'h01;
      done      <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            slot[0] <= key;
            for (int unsigned i = 1; i < 11; i++) slot[i] <= '0;
            prev_key  <= key;
            round_cnt <= 4'd1;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
          end
        end
        EXPAND: begin
          for (int unsigned i = 1; i < 11; i++) begin
            if (round_cnt == 4'(i)) slot[i] <= round_key;
          end
          prev_key  <= round_key;
          round_cnt <= round_cnt + 4'd1;
          rcon      <= xtime(rcon);
          if (round_cnt == 4'd10) begin
            round_cnt <= '0;
            key_valid <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expander.sv
// Directed bench for key_expander using FIPS-197 reference schedules.
module tb_key_expander;

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key;
  logic          busy;
  logic          done;
  logic          key_valid;
  logic [1407:0] expanded_key;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_expander dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key          (key),
    .busy         (busy),
    .done         (done),
    .key_valid    (key_valid),
    .expanded_key (expanded_key)
  );

  function automatic logic [127:0] rk(input int unsigned r);
    return expanded_key[(10 - r) * 128 +: 128];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    n_cmp++; if (expanded_key !== '0) begin n_err++; $display("FAIL reset_expanded_key: got nonzero expected 0"); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_a1();
    int hi_done = 0;
    int lo_busy = 0;
    key = A1_KEY; start = 1'b1;
    tick();
    start = 1'b0; key = 128'hdeadbeef_00112233_44556677_8899aabb;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL a1_busy_t0: got %b expected 1", busy); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL a1_kv_t0: got %b expected 0", key_valid); end
    n_cmp++; if (rk(0) !== A1_KEY) begin n_err++; $display("FAIL a1_round0_t0: got %h expected %h", rk(0), A1_KEY); end
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (done !== 1'b0) hi_done++;
      if (busy !== 1'b1) lo_busy++;
    end
    n_cmp++; if (hi_done !== 0) begin n_err++; $display("FAIL a1_early_done: got %0d expected 0", hi_done); end
    n_cmp++; if (lo_busy !== 0) begin n_err++; $display("FAIL a1_busy_drop: got %0d expected 0", lo_busy); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL a1_done_t10: got %b expected 1", done); end
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL a1_kv_t10: got %b expected 1", key_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL a1_busy_t10: got %b expected 0", busy); end
    n_cmp++; if (rk(0) !== A1_KEY) begin n_err++; $display("FAIL a1_round0: got %h expected %h", rk(0), A1_KEY); end
    n_cmp++; if (rk(1) !== A1_R1) begin n_err++; $display("FAIL a1_round1: got %h expected %h", rk(1), A1_R1); end
    n_cmp++; if (rk(10) !== A1_R10) begin n_err++; $display("FAIL a1_round10: got %h expected %h", rk(10), A1_R10); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL a1_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_idle_hold();
    int hi_done = 0;
    int lo_kv   = 0;
    int bad_rk  = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done !== 1'b0) hi_done++;
      if (key_valid !== 1'b1) lo_kv++;
      if (rk(0) !== A1_KEY || rk(1) !== A1_R1 || rk(10) !== A1_R10) bad_rk++;
    end
    n_cmp++; if (hi_done !== 0) begin n_err++; $display("FAIL idle_done: got %0d highs expected 0", hi_done); end
    n_cmp++; if (lo_kv !== 0) begin n_err++; $display("FAIL idle_key_valid: got %0d lows expected 0", lo_kv); end
    n_cmp++; if (bad_rk !== 0) begin n_err++; $display("FAIL idle_schedule: got %0d changed cycles expected 0", bad_rk); end
  endtask

  task automatic test_busy_ignore_zero();
    key = '0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    key = A1_KEY; start = 1'b1;
    tick();
    start = 1'b0; key = '0;
    for (int i = 0; i < 6; i++) tick();
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b expected 1", done); end
    n_cmp++; if (rk(0) !== '0) begin n_err++; $display("FAIL zero_round0: got %h expected 0", rk(0)); end
    n_cmp++; if (rk(1) !== Z_R1) begin n_err++; $display("FAIL zero_round1: got %h expected %h", rk(1), Z_R1); end
    n_cmp++; if (rk(10) !== Z_R10) begin n_err++; $display("FAIL zero_round10: got %h expected %h", rk(10), Z_R10); end
  endtask

  task automatic test_restart_on_done();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL restart_pre_done: got %b expected 1", done); end
    key = A1_KEY; start = 1'b1;
    tick();
    start = 1'b0; key = '0;
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL restart_kv: got %b expected 0", key_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL restart_done_drop: got %b expected 0", done); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b expected 1", busy); end
    for (int i = 0; i < 9; i++) tick();
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b expected 1", done); end
    n_cmp++; if (rk(1) !== A1_R1) begin n_err++; $display("FAIL restart_round1: got %h expected %h", rk(1), A1_R1); end
    n_cmp++; if (rk(10) !== A1_R10) begin n_err++; $display("FAIL restart_round10: got %h expected %h", rk(10), A1_R10); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    logic exp_busy;
    logic [127:0] exp_r1;
    logic [127:0] exp_r10;
    for (int c = 0; c <= 34; c++) begin
      start = (c < 25);
      if (c == 11) key = A1_KEY;
      else if (c == 0 || c == 22) key = '0;
      else key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      exp_done = (c == 10 || c == 21 || c == 32);
      exp_busy = !(c == 10 || c == 21 || c >= 32);
      n_cmp++; if (done !== exp_done) begin n_err++; $display("FAIL b2b_done c=%0d: got %b expected %b", c, done, exp_done); end
      n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy, exp_busy); end
      if (exp_done) begin
        exp_r1  = (c == 21) ? A1_R1  : Z_R1;
        exp_r10 = (c == 21) ? A1_R10 : Z_R10;
        n_cmp++; if (rk(1) !== exp_r1) begin n_err++; $display("FAIL b2b_round1 c=%0d: got %h expected %h", c, rk(1), exp_r1); end
        n_cmp++; if (rk(10) !== exp_r10) begin n_err++; $display("FAIL b2b_round10 c=%0d: got %h expected %h", c, rk(10), exp_r10); end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_abort();
    int hi_done = 0;
    int hi_busy = 0;
    key = A1_KEY; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (rk(1) !== A1_R1) begin n_err++; $display("FAIL abort_partial_round1: got %h expected %h", rk(1), A1_R1); end
    n_cmp++; if (rk(2) !== '0) begin n_err++; $display("FAIL abort_partial_round2: got %h expected 0", rk(2)); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL abort_partial_kv: got %b expected 0", key_valid); end
    tick(); tick(); tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL abort_kv: got %b expected 0", key_valid); end
    n_cmp++; if (expanded_key !== '0) begin n_err++; $display("FAIL abort_expanded_key: got nonzero expected 0"); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done !== 1'b0) hi_done++;
      if (busy !== 1'b0) hi_busy++;
    end
    n_cmp++; if (hi_done !== 0) begin n_err++; $display("FAIL abort_late_done: got %0d highs expected 0", hi_done); end
    n_cmp++; if (hi_busy !== 0) begin n_err++; $display("FAIL abort_late_busy: got %0d highs expected 0", hi_busy); end
  endtask

  task automatic test_start_after_reset();
    key = '0; start = 1'b1;
    tick();
    start = 1'b0; key = A1_KEY;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL post_rst_busy: got %b expected 1", busy); end
    for (int i = 0; i < 9; i++) tick();
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL post_rst_done: got %b expected 1", done); end
    n_cmp++; if (rk(0) !== '0) begin n_err++; $display("FAIL post_rst_round0: got %h expected 0", rk(0)); end
    n_cmp++; if (rk(1) !== Z_R1) begin n_err++; $display("FAIL post_rst_round1: got %h expected %h", rk(1), Z_R1); end
    n_cmp++; if (rk(10) !== Z_R10) begin n_err++; $display("FAIL post_rst_round10: got %h expected %h", rk(10), Z_R10); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; key = '0;
    test_reset();
    test_fips_a1();
    test_idle_hold();
    test_busy_ignore_zero();
    test_restart_on_done();
    test_back_to_back();
    test_reset_abort();
    test_start_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_expander.md
KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 The block SHALL have a single clock domain; all state SHALL update on the rising edge of clk.
REQ-002 Reset SHALL be synchronous and active-high on port rst.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to expand key; sampled on each rising edge.
REQ-006 key  input  128  AES-128 cipher key, FIPS-197 byte order (bits [127:120] = byte 0); sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while expansion is in progress.
REQ-008 done  output  1  single-cycle pulse marking expansion complete.
REQ-009 key_valid  output  1  level; high while expanded_key holds a complete schedule for the last accepted key.
REQ-010 expanded_key  output  1408  round keys 0..10; round key r SHALL occupy bits [1407-128r : 1280-128r], so round 0 sits in the MSBs and round 10 in bits [127:0].

Function
REQ-011 The block SHALL be an iterative FSM with two states: IDLE and EXPAND.
REQ-012 In IDLE, start=1 SHALL be accepted: round-0 slot <= key, slots 1..10 <= 0, round counter <= 1, Rcon <= 0x01, key_valid <= 0, state <= EXPAND.
REQ-013 In EXPAND, each edge SHALL compute one round key from the previous slot and write it into slot[counter], then increment counter and advance Rcon.
REQ-014 Round computation SHALL follow FIPS-197: temp = SubWord(RotWord(w3)) xor {Rcon,00,00,00}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-015 SubWord SHALL use four parallel combinational FIPS-197 S-box lookups; no multi-cycle S-box access.
REQ-016 The Rcon sequence SHALL be 01,02,04,08,10,20,40,80,1B,36 (GF(2^8) doubling with 0x1B reduction on MSB overflow).
REQ-017 The edge writing round 10 SHALL return state to IDLE, set key_valid <= 1, and assert done for exactly the following cycle.
REQ-018 Latency: with start accepted at edge T0, done and key_valid SHALL first be high after edge T10; busy SHALL be high after edges T0..T9 and low after T10.
REQ-019 busy SHALL equal (state == EXPAND).
REQ-020 start while busy=1 SHALL be ignored; the key input SHALL not be resampled.
REQ-021 start in the cycle where done=1 SHALL be accepted (state is IDLE); done then deasserts and key_valid clears on that same edge.
REQ-022 expanded_key SHALL hold its value in IDLE indefinitely with no further toggling until the next accepted start.
REQ-023 Partially written slots SHALL be visible on expanded_key during EXPAND; consumers SHALL qualify with key_valid.

Reset
REQ-024 rst=1 SHALL force state IDLE, counter 0, Rcon 0x01, busy=0, done=0, key_valid=0, expanded_key=0 on the next edge.
REQ-025 rst SHALL take priority over start and over an in-progress expansion; an aborted expansion SHALL not produce done.
REQ-026 After rst deasserts, the first start SHALL behave exactly as REQ-012.

Verification
REQ-027 FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, one-cycle start -> done 10 cycles later; round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, round 0 = key.
REQ-028 All-zero key -> round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 start held high for 25 cycles with key changing every cycle -> expansions complete back-to-back every 11 cycles; each schedule matches the key present on its accepting edge.
REQ-030 rst asserted 5 cycles after start -> busy, key_valid, done, expanded_key all 0 next cycle; no done pulse follows.
REQ-031 start pulsed on the cycle done=1 with a new key -> key_valid drops on that edge, second done exactly 10 cycles later with the new schedule.
REQ-032 Idle 100 cycles after completion with start=0 -> expanded_key unchanged, key_valid stays 1, done stays 0.
